// File: rtl/capture_sequencer_if.sv
// Handshake and status bundle between the capture sequencer and its controller.
interface capture_sequencer_if;
    logic [31:0] inst_data;
    logic        arm;
    logic        abort;
    logic        tx_busy;
    logic        tx_done;
    logic        record_valid;
    logic        capture_end;
    logic        seq_done;
    logic [7:0]  run_count;
    logic        retrig_err;
    logic [2:0]  state;

    modport master (
        output inst_data, arm, abort, tx_busy, tx_done,
        input  record_valid, capture_end, seq_done, run_count, retrig_err, state
    );

    modport slave (
        input  inst_data, arm, abort, tx_busy, tx_done,
        output record_valid, capture_end, seq_done, run_count, retrig_err, state
    );
endinterface

// File: rtl/capture_sequencer.sv
// Instruction-triggered sensor capture sequencer: opens a record window after a trigger,
// then hands off to the UART send stage. Macro SEQ_AUTO_REARM_EN enables NUM_RUNS auto re-arm.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | waiting for a trigger match with the send stage idle
// COUNT   | cycle counter running, record window open inside it
// HANDOFF | window closed, waiting for tx_done
// DONE    | sequence complete, waiting for a new arm
module capture_sequencer #(
    parameter logic [31:0] INST_MATCH = 32'h0110b020,
    parameter logic [31:0] INST_MASK  = 32'hFFFFFFFF,
    parameter int unsigned WIN_START  = 1,
    parameter int unsigned WIN_LEN    = 5,
    parameter int unsigned NUM_RUNS   = 4
) (
    input logic                cpu_clk,
    input logic                rst,
    capture_sequencer_if.slave sif
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        COUNT   = 3'd2,
        HANDOFF = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] WIN_S = 8'(WIN_START);
    localparam logic [7:0] WIN_E = 8'(WIN_START + WIN_LEN);

    if ((WIN_START < 1) || (WIN_START > 254) || (WIN_START + WIN_LEN > 255) ||
        (NUM_RUNS < 1) || (NUM_RUNS > 255)) begin : g_bad_cfg
        $error("capture_sequencer: parameter out of legal range");
    end

`ifdef SEQ_AUTO_REARM_EN
    localparam logic [8:0] RUNS_W = 9'(NUM_RUNS);
`endif

    state_t     state_q;
    logic [7:0] cnt;
    logic [7:0] run_count_q;
    logic       retrig_err_q;
    logic       capture_end_q;
    logic       seq_done_q;
    logic       match;

    assign match = (sif.inst_data & INST_MASK) == (INST_MATCH & INST_MASK);

    // Combinational so an asynchronous reset of state_q closes the window at once.
    assign sif.record_valid = (state_q == COUNT) && (cnt >= WIN_S) && (cnt < WIN_E);
    assign sif.capture_end  = capture_end_q;
    assign sif.seq_done     = seq_done_q;
    assign sif.run_count    = run_count_q;
    assign sif.retrig_err   = retrig_err_q;
    assign sif.state        = state_q;

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt           <= 8'd0;
            run_count_q   <= 8'd0;
            retrig_err_q  <= 1'b0;
            capture_end_q <= 1'b0;
            seq_done_q    <= 1'b0;
        end else if (sif.abort) begin
            state_q       <= IDLE;
            cnt           <= 8'd0;
            capture_end_q <= 1'b0;
            seq_done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sif.arm) begin
                        state_q      <= ARMED;
                        run_count_q  <= 8'd0;
                        retrig_err_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (match && !sif.tx_busy) begin
                        state_q <= COUNT;
                        cnt     <= 8'd1;
                    end
                end
                COUNT: begin
                    if (match) retrig_err_q <= 1'b1;
                    if (cnt == WIN_E) begin
                        state_q       <= HANDOFF;
                        capture_end_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HANDOFF: begin
                    if (sif.tx_done) begin
                        run_count_q   <= (run_count_q == 8'hFF) ? 8'hFF : run_count_q + 8'd1;
                        capture_end_q <= 1'b0;
`ifdef SEQ_AUTO_REARM_EN
                        if (({1'b0, run_count_q} + 9'd1) < RUNS_W) begin
                            state_q <= ARMED;
                        end else begin
                            state_q    <= DONE;
                            seq_done_q <= 1'b1;
                        end
`else
                        state_q    <= DONE;
                        seq_done_q <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (sif.arm) begin
                        state_q      <= ARMED;
                        seq_done_q   <= 1'b0;
                        run_count_q  <= 8'd0;
                        retrig_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    cnt           <= 8'd0;
                    capture_end_q <= 1'b0;
                    seq_done_q    <= 1'b0;
                end
            endcase
        end
    end
endmodule
